ram_scalar_v3: RTL and testbench

RAM_SCALAR_V3 -- requirements
Module: ram_scalar_v3

---
 rtl/ram_scalar_v3.sv | 87 ++++++++
 tb/tb_ram_scalar_v3.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/ram_scalar_v3.sv
// ram_scalar_v3: single-port word-addressed RAM with a registered read port.
// Reads are write-through on a same-address read/write; out-of-range
// accesses drop writes and return zero. Reset clears only the output
// register(s), never the array.
// Optional macro RAM_SCALAR_V3_OUT_REG_EN adds a second output register,
// giving a read latency of 2 instead of 1.
module ram_scalar_v3 #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned ADDR_WIDTH = 24,
    parameter int unsigned DEPTH      = 8192
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  rden,
    input  logic                  wren,
    output logic [DATA_WIDTH-1:0] q
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One extra bit so a DEPTH that equals 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] DepthExt = (ADDR_WIDTH + 1)'(DEPTH);

    // Zero-initialised array; reset deliberately leaves it alone.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

    logic                  in_range;
    logic [IdxW-1:0]       idx;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] rd_d, rd_q;

    // Address decode and write qualification (reset wins over the write).
    always_comb begin
        in_range = ({1'b0, address} < DepthExt);
        idx      = address[IdxW-1:0];
        mem_we   = wren && !reset && in_range;
    end

    // Storage array write port.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[idx] <= data;
        end
    end

    // First read stage next-state: hold, clear, zero out-of-range, or write-through.
    always_comb begin
        rd_d = rd_q;
        if (reset) begin
            rd_d = '0;
        end else if (rden) begin
            if (!in_range) begin
                rd_d = '0;
            end else if (wren) begin
                rd_d = data;
            end else begin
                rd_d = mem_q[idx];
            end
        end
    end

    // First read stage register.
    always_ff @(posedge clock) begin
        rd_q <= rd_d;
    end

`ifdef RAM_SCALAR_V3_OUT_REG_EN
    logic [DATA_WIDTH-1:0] out_d, out_q;

    // Second stage follows the first on every edge.
    always_comb begin
        out_d = reset ? '0 : rd_q;
    end

    // Second output register.
    always_ff @(posedge clock) begin
        out_q <= out_d;
    end

    assign q = out_q;
`else
    assign q = rd_q;
`endif

endmodule

// File: tb/tb_ram_scalar_v3.sv
// Directed bench for ram_scalar_v3 with hand-computed expected values.
// Works with or without RAM_SCALAR_V3_OUT_REG_EN defined.
module tb_ram_scalar_v3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] address = '0;
    logic [23:0] data = '0;
    logic        rden = 1'b0;
    logic        wren = 1'b0;
    logic [23:0] q;

    int vec_cnt = 0;
    int err_cnt = 0;

    ram_scalar_v3 dut (
        .clock   (clock),
        .reset   (reset),
        .address (address),
        .data    (data),
        .rden    (rden),
        .wren    (wren),
        .q       (q)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %06h expected %06h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Apply one access for a single edge.
    task automatic op(input logic r, input logic w, input logic [23:0] a, input logic [23:0] d);
        rden    = r;
        wren    = w;
        address = a;
        data    = d;
        step();
    endtask

    // Go idle and let the optional second output stage catch up.
    task automatic settle();
        rden = 1'b0;
        wren = 1'b0;
`ifdef RAM_SCALAR_V3_OUT_REG_EN
        step();
`endif
    endtask

    initial begin
        // Reset for two cycles.
        reset = 1'b1;
        op(1'b0, 1'b0, 24'h1000, 24'h0);
        op(1'b0, 1'b0, 24'h1000, 24'h0);
        check("reset_q", q, 24'h000000);

        // Idle with rden=0: q stays 0.
        reset = 1'b0;
        op(1'b0, 1'b0, 24'h1000, 24'h0);
        check("idle0_q", q, 24'h000000);
        op(1'b0, 1'b0, 24'h1000, 24'h0);
        check("idle1_q", q, 24'h000000);

        // Read-during-write at 0x1001 is write-through.
        op(1'b1, 1'b1, 24'h1001, 24'hABCDEF);
`ifdef RAM_SCALAR_V3_OUT_REG_EN
        check("wt_lat2_early", q, 24'h000000);
`endif
        settle();
        check("wt_q", q, 24'hABCDEF);

        // Plain read back confirms the memory was written.
        op(1'b1, 1'b0, 24'h1001, 24'h0);
        settle();
        check("rd_1001", q, 24'hABCDEF);

        // Write with rden=0 leaves q alone.
        op(1'b0, 1'b1, 24'h1002, 24'h123456);
        settle();
        check("wr_nord_q", q, 24'hABCDEF);
        op(1'b0, 1'b0, 24'h1002, 24'h0);
        check("hold0_q", q, 24'hABCDEF);
        op(1'b0, 1'b1, 24'h1001, 24'h777777);
        check("hold1_q", q, 24'hABCDEF);
        op(1'b1, 1'b0, 24'h1002, 24'h0);
        settle();
        check("rd_1002", q, 24'h123456);

        // Restore 0x1001 (the hold1 write changed it) and boundary word 0x1FFF.
        op(1'b0, 1'b1, 24'h1001, 24'hABCDEF);
        op(1'b0, 1'b1, 24'h1FFF, 24'h5A5A5A);
        op(1'b1, 1'b0, 24'h1FFF, 24'h0);
        settle();
        check("rd_1fff", q, 24'h5A5A5A);

        // Out-of-range write is dropped; out-of-range read returns 0.
        op(1'b0, 1'b1, 24'h2000, 24'h00FFFF);
        op(1'b1, 1'b0, 24'h2000, 24'h0);
        settle();
        check("rd_2000", q, 24'h000000);
        op(1'b1, 1'b0, 24'h0000, 24'h0);
        settle();
        check("no_alias_0", q, 24'h000000);
        op(1'b1, 1'b0, 24'h801001, 24'h0);
        settle();
        check("rd_hi_oor", q, 24'h000000);
        op(1'b1, 1'b1, 24'h2001, 24'h424242);
        settle();
        check("wt_oor", q, 24'h000000);
        op(1'b1, 1'b0, 24'h1001, 24'h0);
        settle();
        check("rd_1001_after", q, 24'hABCDEF);

        // Inputs changed between edges have no effect; only the edge value counts.
        rden    = 1'b1;
        wren    = 1'b0;
        address = 24'h1FFF;
        #3;
        address = 24'h1002;
        step();
        settle();
        check("mid_cycle", q, 24'h123456);

        // Reset pulse with a pending write: q clears, write is discarded.
        op(1'b1, 1'b0, 24'h1001, 24'h0);
        settle();
        check("pre_rst_q", q, 24'hABCDEF);
        reset = 1'b1;
        op(1'b1, 1'b1, 24'h1001, 24'h111111);
        check("rst_pulse_q", q, 24'h000000);
        reset = 1'b0;
        op(1'b1, 1'b0, 24'h1001, 24'h0);
        settle();
        check("post_rst_rd", q, 24'hABCDEF);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
